// File: rtl/koa_arb_ctrl_pkg.sv
// koa_arb_ctrl_pkg
// Shared definitions for the two-requester KOA multiplier front end.
//   state_t : controller FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   CNT_W   : width of the multicycle down-counter; holds LAT-1 for LAT in 1..15
package koa_arb_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/KOA_c.sv
// KOA_c
// Combinational unsigned Karatsuba-Ofman multiplier. Each level splits the
// operands into high/low halves and forms the product from three narrower
// products: z2 = hi*hi, z0 = lo*lo, z1 = (hi+lo)*(hi+lo).
// The level below is another KOA_c with DEPTH-1. Recursion stops at DEPTH=0
// or at small widths, where a plain multiply is cheaper than another split.
// precision=0 forces the plain multiply at this level; precision=1 allows
// the decomposition. Either way the full 2*SW-bit product is produced.
// Ports:
//   data_a, data_b : SW-bit unsigned operands
//   sgf_result     : 2*SW-bit unsigned product
module KOA_c #(
    parameter int SW        = 54,
    parameter int DEPTH     = 4,
    parameter int precision = 1
) (
    input  logic [SW-1:0]   data_a,
    input  logic [SW-1:0]   data_b,
    output logic [2*SW-1:0] sgf_result
);

    generate
        if (DEPTH == 0 || SW < 8 || precision == 0) begin : g_leaf
            assign sgf_result = {{SW{1'b0}}, data_a} * {{SW{1'b0}}, data_b};
        end else begin : g_split
            localparam int L = SW / 2;
            localparam int H = SW - L;

            logic [L-1:0]     a_lo, b_lo;
            logic [H-1:0]     a_hi, b_hi;
            logic [H:0]       a_sum, b_sum;
            logic [2*L-1:0]   z0;
            logic [2*H-1:0]   z2;
            logic [2*H+1:0]   z1;
            logic [2*H+1:0]   mid;
            logic [2*SW-1:0]  mid_ext;

            assign a_lo  = data_a[L-1:0];
            assign b_lo  = data_b[L-1:0];
            assign a_hi  = data_a[SW-1:L];
            assign b_hi  = data_b[SW-1:L];
            assign a_sum = {1'b0, a_hi} + {{(H+1-L){1'b0}}, a_lo};
            assign b_sum = {1'b0, b_hi} + {{(H+1-L){1'b0}}, b_lo};

            KOA_c #(.SW(L), .DEPTH(DEPTH-1), .precision(precision)) u_lo (
                .data_a     (a_lo),
                .data_b     (b_lo),
                .sgf_result (z0)
            );

            KOA_c #(.SW(H), .DEPTH(DEPTH-1), .precision(precision)) u_hi (
                .data_a     (a_hi),
                .data_b     (b_hi),
                .sgf_result (z2)
            );

            KOA_c #(.SW(H+1), .DEPTH(DEPTH-1), .precision(precision)) u_mid (
                .data_a     (a_sum),
                .data_b     (b_sum),
                .sgf_result (z1)
            );

            // The cross term z1 - z2 - z0 is never negative, so unsigned
            // subtraction in the z1 width is exact.
            assign mid        = z1 - {2'b00, z2} - {{(2*H+2-2*L){1'b0}}, z0};
            assign mid_ext    = {{(2*SW-2*H-2){1'b0}}, mid};
            assign sgf_result = {z2, z0} + (mid_ext << L);
        end
    endgenerate

endmodule

// File: rtl/koa_arb_ctrl.sv
// koa_arb_ctrl
// Round-robin front end that shares one KOA_c multiplier between two
// requesters. A grant captures the winner's operand pair. The multiplier
// then evaluates for LAT cycles as a multicycle path, because the operand
// registers hold still until the FSM returns to IDLE. The product waits in
// DONE until the consumer takes it.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   reqN_valid / reqN_ready  : requester N handshake (ready = grant this cycle)
//   reqN_a, reqN_b           : requester N operands (SW bits)
//   res_valid / res_ready    : result handshake
//   res_id                   : requester that owns res_data
//   res_data                 : 2*SW-bit unsigned product
//   busy                     : controller not in IDLE
module koa_arb_ctrl
    import koa_arb_ctrl_pkg::*;
#(
    parameter int SW    = 54,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [SW-1:0]   req0_a,
    input  logic [SW-1:0]   req0_b,
    input  logic [SW-1:0]   req1_a,
    input  logic [SW-1:0]   req1_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_id,
    output logic [2*SW-1:0] res_data,
    output logic            busy
);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [SW-1:0]      op_a, op_b;
    logic               ptr;
    logic               grant_any;
    logic               grant_id;
    logic               load_res;
    logic [2*SW-1:0]    koa_result;

    KOA_c #(.SW(SW), .DEPTH(DEPTH), .precision(1)) u_koa (
        .data_a     (op_a),
        .data_b     (op_b),
        .sgf_result (koa_result)
    );

    // Next-state and handshake decode. A grant happens only in IDLE and
    // never during a reset cycle. When both requesters are valid, the winner
    // is the one the pointer favours. A lone valid wins regardless of the
    // pointer.
    always_comb begin
        next_state = state;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        load_res   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (rst && (req0_valid || req1_valid)) begin
                    grant_any  = 1'b1;
                    grant_id   = (req0_valid && req1_valid) ? ptr : req1_valid;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    next_state = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    load_res   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and datapath registers. The operand registers and id change only
    // on a grant, and res_data changes only on the last CALC cycle. Both stay
    // stable through CALC and DONE. After a grant the pointer favours the
    // loser.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res_data <= '0;
            res_id   <= 1'b0;
            ptr      <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_any) begin
                op_a   <= grant_id ? req1_a : req0_a;
                op_b   <= grant_id ? req1_b : req0_b;
                res_id <= grant_id;
                ptr    <= ~grant_id;
                cnt    <= CNT_W'(LAT - 1);
            end else if (state == CALC && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (load_res) begin
                res_data <= koa_result;
            end
        end
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_koa_arb_ctrl.sv
// tb_koa_arb_ctrl
// Self-checking bench for koa_arb_ctrl. The main instance (LAT=2) runs a table
// of transactions followed by hand-written corner sequences. Expected results
// go into a scoreboard queue at grant time and are popped when the result
// handshake completes. Two extra instances (LAT=1, LAT=15) share a separate
// stimulus set and are used to measure grant-to-result distance.
module tb_koa_arb_ctrl;

    localparam int SW  = 54;
    localparam int LAT = 2;

    typedef struct {
        logic            v0;
        logic            v1;
        logic [SW-1:0]   a0;
        logic [SW-1:0]   b0;
        logic [SW-1:0]   a1;
        logic [SW-1:0]   b1;
        logic            exp_id;
        logic [2*SW-1:0] exp_data;
        int              hold;
    } vec_t;

    typedef struct {
        logic            id;
        logic [2*SW-1:0] data;
    } sb_t;

    logic            clk;
    logic            rst;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [SW-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic            res_valid, res_ready, res_id, busy;
    logic [2*SW-1:0] res_data;

    logic            lx_req0_valid, lx_req1_valid, lx_res_ready;
    logic [SW-1:0]   lx_req0_a, lx_req0_b, lx_req1_a, lx_req1_b;
    logic            l1_req0_ready, l1_req1_ready, l1_res_valid, l1_res_id, l1_busy;
    logic [2*SW-1:0] l1_res_data;
    logic            l15_req0_ready, l15_req1_ready, l15_res_valid, l15_res_id, l15_busy;
    logic [2*SW-1:0] l15_res_data;

    vec_t vecs[7];
    sb_t  sb[$];
    int   checks = 0;
    int   passes = 0;

    koa_arb_ctrl #(.SW(SW), .DEPTH(4), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_data(res_data), .busy(busy)
    );

    koa_arb_ctrl #(.SW(SW), .DEPTH(4), .LAT(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req0_valid(lx_req0_valid), .req1_valid(lx_req1_valid),
        .req0_ready(l1_req0_ready), .req1_ready(l1_req1_ready),
        .req0_a(lx_req0_a), .req0_b(lx_req0_b), .req1_a(lx_req1_a), .req1_b(lx_req1_b),
        .res_valid(l1_res_valid), .res_ready(lx_res_ready), .res_id(l1_res_id),
        .res_data(l1_res_data), .busy(l1_busy)
    );

    koa_arb_ctrl #(.SW(SW), .DEPTH(4), .LAT(15)) dut_l15 (
        .clk(clk), .rst(rst),
        .req0_valid(lx_req0_valid), .req1_valid(lx_req1_valid),
        .req0_ready(l15_req0_ready), .req1_ready(l15_req1_ready),
        .req0_a(lx_req0_a), .req0_b(lx_req0_b), .req1_a(lx_req1_a), .req1_b(lx_req1_b),
        .res_valid(l15_res_valid), .res_ready(lx_res_ready), .res_id(l15_res_id),
        .res_data(l15_res_data), .busy(l15_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product, computed at full width independently of the DUT.
    function automatic logic [2*SW-1:0] prod(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
    endfunction

    task automatic check(input string name, input logic [2*SW-1:0] act, input logic [2*SW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Pulse reset for one cycle with both valids high so the reset-cycle
    // ready masking is exercised, then release at a negedge.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        #1;
        check("rst_r0", req0_ready, 0);
        check("rst_r1", req1_ready, 0);
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_id", res_id, 0);
    endtask

    // Called at a negedge with the DUT in IDLE. Drive one request pattern,
    // check the grant, and queue the expected result.
    task automatic apply_stimulus(input vec_t v);
        sb_t e;
        req0_valid = v.v0; req1_valid = v.v1;
        req0_a = v.a0; req0_b = v.b0; req1_a = v.a1; req1_b = v.b1;
        #1;
        check("grant_busy", busy, 0);
        check("grant_r0", req0_ready, !v.exp_id);
        check("grant_r1", req1_ready, v.exp_id);
        e.id = v.exp_id;
        e.data = v.exp_data;
        sb.push_back(e);
    endtask

    // Follow the transaction granted by apply_stimulus. Returns at the first
    // negedge after the result was consumed, when the DUT is back in IDLE.
    task automatic check_output(input int hold);
        int  lat;
        sb_t e;
        @(negedge clk);
        lat = 1;
        check("calc_r0", req0_ready, 0);
        check("calc_r1", req1_ready, 0);
        check("calc_busy", busy, 1);
        while (!res_valid && lat < LAT + 6) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, LAT + 1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            if (res_valid) begin
                res_ready = 1'b0;
                req0_valid = 1'b1; req1_valid = 1'b1;
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    check("hold_valid", res_valid, 1);
                    check("hold_data", res_data, e.data);
                    check("hold_id", res_id, e.id);
                    check("hold_busy", busy, 1);
                    check("hold_r0", req0_ready, 0);
                    check("hold_r1", req1_ready, 0);
                end
                res_ready = 1'b1;
                #1;
                check("res_data", res_data, e.data);
                check("res_id", res_id, e.id);
                @(negedge clk);
                res_ready = 1'b0;
            end
        end
    endtask

    initial begin
        automatic logic [SW-1:0]   max_v = {SW{1'b1}};
        automatic logic [2*SW-1:0] max_sq = ~(2*SW)'(0) - ((2*SW)'(1) << 55) + (2*SW)'(2);
        automatic logic [SW-1:0]   ra0, rb0, ra1, rb1, rc0, rc1;
        vec_t v;
        int   d1, d15;
        logic [2*SW-1:0] q1, q15;
        logic i1, i15;

        rst = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        lx_req0_valid = 1'b0; lx_req1_valid = 1'b0; lx_res_ready = 1'b0;
        lx_req0_a = '0; lx_req0_b = '0; lx_req1_a = '0; lx_req1_b = '0;

        repeat (2) @(negedge clk);
        check("init_r0", req0_ready, 0);
        check("init_r1", req1_ready, 0);
        check("init_busy", busy, 0);
        check("init_valid", res_valid, 0);
        check("init_data", res_data, 0);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

        // res_ready while idle must not move the FSM.
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready_busy", busy, 0);
        check("idle_ready_valid", res_valid, 0);
        res_ready = 1'b0;

        ra0 = {22'($urandom), 32'($urandom)}; rb0 = {22'($urandom), 32'($urandom)};
        ra1 = {22'($urandom), 32'($urandom)}; rb1 = {22'($urandom), 32'($urandom)};
        rc0 = {22'($urandom), 32'($urandom)}; rc1 = {22'($urandom), 32'($urandom)};

        // Expected ids follow the round-robin pointer starting at req0.
        vecs[0] = '{1'b1, 1'b0, 54'd3, 54'd5, 54'd0, 54'd0, 1'b0, 108'd15, 0};
        vecs[1] = '{1'b1, 1'b1, 54'd7, 54'd9, 54'd11, 54'd13, 1'b1, 108'd143, 0};
        vecs[2] = '{1'b0, 1'b1, 54'd1, 54'd1, max_v, max_v, 1'b1, max_sq, 10};
        vecs[3] = '{1'b1, 1'b1, 54'd0, max_v, 54'd6, 54'd6, 1'b0, 108'd0, 0};
        vecs[4] = '{1'b1, 1'b0, 54'd1 << 53, 54'd3, 54'd2, 54'd2, 1'b0, 108'd3 << 53, 0};
        vecs[5] = '{1'b1, 1'b1, ra0, rb0, ra1, rb1, 1'b1, prod(ra1, rb1), 0};
        vecs[6] = '{1'b1, 1'b1, rc0, rc1, ra0, rb1, 1'b0, prod(rc0, rc1), 0};

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i].hold);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // After a fresh reset, both valid and held: req0, req1, req0.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            v = '{1'b1, 1'b1, 54'd3, 54'd5, 54'd4, 54'd6, (i == 1), (i == 1) ? 108'd24 : 108'd15, 0};
            apply_stimulus(v);
            check_output(0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset in the middle of CALC aborts; a new request then completes.
        @(negedge clk);
        v = '{1'b1, 1'b0, 54'd9, 54'd9, 54'd0, 54'd0, 1'b0, 108'd81, 0};
        apply_stimulus(v);
        @(negedge clk);
        check("abort_in_calc", busy, 1);
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("abort_r0", req0_ready, 0);
        check("abort_r1", req1_ready, 0);
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        if (sb.size() > 0) void'(sb.pop_front());
        v = '{1'b0, 1'b1, 54'd0, 54'd0, 54'd12, 54'd12, 1'b1, 108'd144, 0};
        apply_stimulus(v);
        check_output(0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stay_idle", busy, 0);

        // Grant-to-result distance for LAT=1 and LAT=15.
        lx_req0_valid = 1'b1; lx_req0_a = 54'd3; lx_req0_b = 54'd5; lx_res_ready = 1'b1;
        #1;
        check("l1_grant", l1_req0_ready, 1);
        check("l15_grant", l15_req0_ready, 1);
        d1 = 0; d15 = 0; q1 = '0; q15 = '0; i1 = 1'b1; i15 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            lx_req0_valid = 1'b0;
            if (l1_res_valid && d1 == 0) begin d1 = c; q1 = l1_res_data; i1 = l1_res_id; end
            if (l15_res_valid && d15 == 0) begin d15 = c; q15 = l15_res_data; i15 = l15_res_id; end
        end
        lx_res_ready = 1'b0;
        check("l1_latency", d1, 2);
        check("l15_latency", d15, 16);
        check("l1_data", q1, 15);
        check("l15_data", q15, 15);
        check("l1_id", i1, 0);
        check("l15_id", i15, 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
